// File: rtl/zapper_sense.sv
// rtl/zapper_sense.sv - light-gun receiver front end: trigger debounce and frame-locked hit detection
//
// Tracks the pattern generator's flash sequence (trigger -> black frame ->
// white-box frame) and reports a hit when the photodiode saw darkness in the
// black frame and enough light in the white frame.
//
// Optional feature macro: ZAPPER_DARK_CHECK_EN
//   defined   : black frame must stay dark (lit cycles <= DARK_MAX) for a hit
//   undefined : dark counter removed, black_ok fixed at 1
//
// Ports:
//   clk          in   pixel clock, shared with the display path
//   rst_n        in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse when the pattern generator advances
//   trigger_raw  in   zapper switch, asynchronous, active-high
//   light_raw    in   photodiode comparator, asynchronous, active-high on light
//   trigger      out  debounced trigger level
//   detect       out  hit indication, valid during the white frame
//   shots        out  saturating shot count
//   hits         out  saturating hit count
module zapper_sense #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int LIT_MIN      = 64,
  parameter int DARK_MAX     = 16,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       trigger_raw,
  input  logic       light_raw,
  output logic       trigger,
  output logic       detect,
  output logic [7:0] shots,
  output logic [7:0] hits
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIT_MIN_C = CNT_W'(LIT_MIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLACK = 2'd1,
    S_WHITE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic            trig_s1, trig_s2;
  logic            light_s1, light_s2;
  logic [DB_W-1:0] db_cnt;
  logic [CNT_W-1:0] lit_cnt;
  logic            black_ok;
  logic            enter_black;
  logic            black_to_white;
  logic            white_to_hold;

  // Two-flop synchronisers for the asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1  <= 1'b0;
      trig_s2  <= 1'b0;
      light_s1 <= 1'b0;
      light_s2 <= 1'b0;
    end else begin
      trig_s1  <= trigger_raw;
      trig_s2  <= trig_s1;
      light_s1 <= light_raw;
      light_s2 <= light_s1;
    end
  end

  // Debounce: count consecutive cycles the synchronised input disagrees with
  // the output; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      trigger <= 1'b0;
    end else if (trig_s2 == trigger) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt  <= '0;
      trigger <= ~trigger;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Flash sequence FSM. The FSM sees the pre-toggle trigger on a cycle where
  // the debouncer flips it, matching what the consumer samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      case (state_q)
        S_IDLE:  if (trigger) state_d = S_BLACK;
        S_BLACK: state_d = S_WHITE;
        S_WHITE: state_d = S_HOLD;
        S_HOLD:  if (!trigger) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign enter_black    = frame_start && (state_q == S_IDLE) && trigger;
  assign black_to_white = frame_start && (state_q == S_BLACK);
  assign white_to_hold  = frame_start && (state_q == S_WHITE);

`ifdef ZAPPER_DARK_CHECK_EN
  localparam logic [CNT_W-1:0] DARK_MAX_C = CNT_W'(DARK_MAX);

  logic [CNT_W-1:0] dark_cnt, dark_cnt_nx;

  always_comb begin
    dark_cnt_nx = dark_cnt;
    if ((state_q == S_BLACK) && light_s2 && (dark_cnt != CNT_MAX))
      dark_cnt_nx = dark_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dark_cnt <= '0;
    else if (enter_black) dark_cnt <= '0;
    else                  dark_cnt <= dark_cnt_nx;
  end

  // Judged on the count including the boundary cycle, since light on the
  // frame_start cycle still belongs to the black frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              black_ok <= 1'b0;
    else if (black_to_white) black_ok <= (dark_cnt_nx <= DARK_MAX_C);
  end
`else
  assign black_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lit_cnt <= '0;
    end else if (enter_black) begin
      lit_cnt <= '0;
    end else if ((state_q == S_WHITE) && light_s2 && (lit_cnt != CNT_MAX)) begin
      lit_cnt <= lit_cnt + CNT_W'(1);
    end
  end

  // detect stays high through the WHITE-ending frame_start cycle so the
  // consumer samples it there, then clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detect <= 1'b0;
    end else if (white_to_hold) begin
      detect <= 1'b0;
    end else if ((state_q == S_WHITE) && black_ok && (lit_cnt >= LIT_MIN_C)) begin
      detect <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shots <= 8'd0;
      hits  <= 8'd0;
    end else begin
      if (enter_black && (shots != 8'hFF))
        shots <= shots + 8'd1;
      if (white_to_hold && detect && (hits != 8'hFF))
        hits <= hits + 8'd1;
    end
  end

endmodule

// File: tb/tb_zapper_sense.sv
// tb/tb_zapper_sense.sv - randomized bench for zapper_sense with a frame-level reference model
module tb_zapper_sense;

  localparam int DB   = 20;
  localparam int LMIN = 8;
  localparam int DMAX = 3;
  localparam int CW   = 4;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       trigger_raw;
  logic       light_raw;
  logic       trigger;
  logic       detect;
  logic [7:0] shots;
  logic [7:0] hits;

  zapper_sense #(
    .DEBOUNCE_CYC(DB),
    .LIT_MIN     (LMIN),
    .DARK_MAX    (DMAX),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .trigger_raw(trigger_raw),
    .light_raw  (light_raw),
    .trigger    (trigger),
    .detect     (detect),
    .shots      (shots),
    .hits       (hits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Phases: 0 idle, 1 black frame, 2 white frame, 3 hold.
  // Trigger rule: it flips once the last DB synchronised samples (raw delayed
  // by two cycles) all disagree with it.
  bit rq[$];
  bit lq[$];
  int m_phase = 0;
  bit m_trig  = 0;
  bit m_det   = 0;
  bit m_blk_ok = 0;
  int m_shots = 0;
  int m_hits  = 0;
  int m_dark  = 0;
  int m_wlit  = 0;
  bit md_old, md_all, md_lit, md_new;

  task automatic model_reset();
    rq.delete();
    lq.delete();
    repeat (DB + 2) rq.push_back(1'b0);
    repeat (3) lq.push_back(1'b0);
    m_phase = 0; m_trig = 0; m_det = 0; m_blk_ok = 0;
    m_shots = 0; m_hits = 0; m_dark = 0; m_wlit = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      rq.push_front(trigger_raw);
      void'(rq.pop_back());
      lq.push_front(light_raw);
      void'(lq.pop_back());
      md_old = m_trig;
      md_all = 1'b1;
      for (int k = 2; k <= DB + 1; k++)
        if (rq[k] == md_old) md_all = 1'b0;
      md_lit = lq[2];
      md_new = 1'b0;
      if (m_phase == 2 && !frame_start)
        md_new = m_blk_ok && (m_wlit >= LMIN);
      if (md_lit && m_phase == 1) m_dark++;
      if (md_lit && m_phase == 2) m_wlit++;
      if (frame_start) begin
        case (m_phase)
          0: if (md_old) begin
               m_phase = 1; m_dark = 0; m_wlit = 0;
               if (m_shots < 255) m_shots++;
             end
          1: begin
               m_phase = 2;
`ifdef ZAPPER_DARK_CHECK_EN
               m_blk_ok = (m_dark <= DMAX);
`else
               m_blk_ok = 1'b1;
`endif
             end
          2: begin
               m_phase = 3;
               if (m_det && m_hits < 255) m_hits++;
             end
          default: if (!md_old) m_phase = 0;
        endcase
      end
      m_det = md_new;
      if (md_all) m_trig = ~md_old;
    end
  end

  bit seen_det = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("trigger", trigger, m_trig);
      check("detect", detect, m_det);
      check("shots", shots, m_shots);
      check("hits", hits, m_hits);
      if (detect) seen_det = 1'b1;
    end
  end

  // Frame pulses and light stimulus.
  // lmode: 0 random density per frame, 1 clean hit, 2 lamp, 3 short flash, 4 dark.
  int frame_len = 40;
  int lmode     = 4;
  int fs_cnt    = 0;
  int lprob     = 0;
  int wcnt      = 0;

  initial begin
    frame_start = 1'b0;
    light_raw   = 1'b0;
    forever begin
      @(negedge clk);
      if (fs_cnt >= frame_len - 1) begin
        frame_start = 1'b1;
        fs_cnt = 0;
        case ($urandom_range(3))
          0: lprob = 0;
          1: lprob = 5;
          2: lprob = 30;
          default: lprob = 100;
        endcase
      end else begin
        frame_start = 1'b0;
        fs_cnt++;
      end
      if (m_phase == 2) wcnt++;
      else wcnt = 0;
      case (lmode)
        0: light_raw = ($urandom_range(99) < lprob);
        1: light_raw = (m_phase == 2);
        2: light_raw = 1'b1;
        3: light_raw = (m_phase == 2) && (wcnt <= 5);
        default: light_raw = 1'b0;
      endcase
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    trigger_raw = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen_det = 1'b0;
  endtask

  int waited;

  initial begin
    rst_n       = 1'b0;
    trigger_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_trigger", trigger, 0);
    check("reset_detect", detect, 0);
    check("reset_shots", shots, 0);
    check("reset_hits", hits, 0);
    rst_n = 1'b1;

    // Glitch shorter than the debounce window is ignored.
    @(negedge clk);
    trigger_raw = 1'b1;
    repeat (10) @(negedge clk);
    trigger_raw = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch_trigger", trigger, 0);

    // Stable press: trigger follows exactly 2 + DB cycles later.
    trigger_raw = 1'b1;
    repeat (DB + 1) @(posedge clk);
    #1 check("debounce_early", trigger, 0);
    @(posedge clk);
    #1 check("debounce_edge", trigger, 1);
    trigger_raw = 1'b0;
    repeat (120) @(negedge clk);

    // Clean hit, trigger held for six frames: one sequence only.
    do_reset();
    frame_len = 40;
    lmode = 1;
    trigger_raw = 1'b1;
    repeat (40 * 6) @(negedge clk);
    check("hit_shots", shots, 1);
    check("hit_hits", hits, 1);
    check("hit_seen_detect", seen_det, 1);
    trigger_raw = 1'b0;
    repeat (DB + 2 + 45) @(negedge clk);
    check("release_shots", shots, 1);
    trigger_raw = 1'b1;
    repeat (40 * 6) @(negedge clk);
    check("second_shots", shots, 2);
    check("second_hits", hits, 2);
    trigger_raw = 1'b0;

    // Short flash in the white frame: miss.
    do_reset();
    lmode = 3;
    trigger_raw = 1'b1;
    repeat (40 * 5) @(negedge clk);
    check("miss_shots", shots, 1);
    check("miss_hits", hits, 0);
    check("miss_seen_detect", seen_det, 0);

    // Constant light.
    do_reset();
    lmode = 2;
    trigger_raw = 1'b1;
    repeat (40 * 5) @(negedge clk);
    check("lamp_shots", shots, 1);
`ifdef ZAPPER_DARK_CHECK_EN
    check("lamp_hits", hits, 0);
`else
    check("lamp_hits", hits, 1);
`endif

    // Asynchronous reset while detect is high.
    do_reset();
    lmode = 1;
    trigger_raw = 1'b1;
    waited = 0;
    while (!detect && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("wait_detect", detect, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_detect", detect, 0);
    check("async_trigger", trigger, 0);
    check("async_shots", shots, 0);
    check("async_hits", hits, 0);
    trigger_raw = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Randomized trigger activity, frame lengths and light densities.
    lmode = 0;
    for (int seg = 0; seg < 60; seg++) begin
      frame_len   = $urandom_range(20, 60);
      trigger_raw = $urandom_range(1);
      repeat ($urandom_range(5, 120)) @(negedge clk);
    end
    trigger_raw = 1'b0;
    repeat (150) @(negedge clk);

    // Saturation of both counters.
    do_reset();
    frame_len = 12;
    lmode = 1;
    for (int s = 0; s < 300; s++) begin
      trigger_raw = 1'b1;
      repeat (70) @(negedge clk);
      trigger_raw = 1'b0;
      repeat (40) @(negedge clk);
    end
    check("sat_shots", shots, 255);
    check("sat_hits", hits, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
